// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcode/state encodings and instruction word layout
//                for the CPU sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_OP_W    = 4;
    localparam int c_SEL_W   = 2;
    localparam int c_FIELD_W = 16;
    localparam int c_INSTR_W = c_OP_W + c_SEL_W + 2 * c_FIELD_W;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        MOV = 4'd1,
        LDR = 4'd2,
        STR = 4'd3,
        CMP = 4'd4,
        B   = 4'd5,
        BGT = 4'd6,
        BLT = 4'd7,
        BEQ = 4'd8,
        ADD = 4'd9
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXEC     = 3'd2,
        MEM_PTR  = 3'd3,
        MEM_DATA = 3'd4,
        WB       = 3'd5,
        BRANCH   = 3'd6,
        TRAP     = 3'd7
    } state_e;

    typedef struct packed {
        logic [c_OP_W-1:0]    op;
        logic [c_SEL_W-1:0]   s;
        logic [c_FIELD_W-1:0] a;
        logic [c_FIELD_W-1:0] b;
    } instr_t;

    // Reserved s encodings (1x) behave as register mode.
    function automatic logic [c_SEL_W-1:0] norm_sel(input logic [c_SEL_W-1:0] s);
        return s[1] ? 2'b00 : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_if
//  Description : ROM, datapath strobe and data-memory bus of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_sequencer_if #(
    parameter int DATA_WIDTH = 38,
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [3:0]            ex_op;
    logic [1:0]            ex_sel;
    logic [WORD_WIDTH-1:0] ex_a;
    logic [WORD_WIDTH-1:0] ex_b;
    logic                  reg_we;
    logic                  alu_gt;
    logic                  alu_lt;
    logic                  alu_eq;
    logic                  mem_req;
    logic                  mem_we;
    logic [WORD_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [WORD_WIDTH-1:0] mem_rdata;
    logic                  trap;

    modport master (
        output rom_addr, ex_op, ex_sel, ex_a, ex_b, reg_we,
               mem_req, mem_we, mem_addr, trap,
        input  rom_data, alu_gt, alu_lt, alu_eq, mem_ack, mem_rdata
    );

    modport slave (
        input  rom_addr, ex_op, ex_sel, ex_a, ex_b, reg_we,
               mem_req, mem_we, mem_addr, trap,
        output rom_data, alu_gt, alu_lt, alu_eq, mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : Combinational branch-taken decision from opcode and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
    import cpu_pkg::*;
(
    input  wire logic [3:0] i_op,
    input  wire logic       i_gt,
    input  wire logic       i_lt,
    input  wire logic       i_eq,
    output logic            o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_op)
            B:       o_taken = 1'b1;
            BGT:     o_taken = i_gt;
            BLT:     o_taken = i_lt;
            BEQ:     o_taken = i_eq;
            default: o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multi-cycle fetch/decode/execute controller. Owns the PC,
//                drives datapath strobes and the data-memory handshake.
//                Optional single-step gating under SEQ_SINGLE_STEP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 38,
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  wire logic       step_en,
    input  wire logic       step,
`endif
    cpu_sequencer_if.master bus
);

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    instr_t                r_ir;
    instr_t                w_ir_next;
    logic [WORD_WIDTH-1:0] r_exb;
    logic [WORD_WIDTH-1:0] w_exb_next;
    logic [2:0]            r_flags;        // {gt, lt, eq}
    logic [2:0]            w_flags_next;
    logic                  w_reg_we;
    logic                  w_mem_req;
    logic                  w_mem_we;
    logic [WORD_WIDTH-1:0] w_mem_addr;
    logic                  w_taken;
    logic                  w_fetch_go;

`ifdef SEQ_SINGLE_STEP_EN
    assign w_fetch_go = !step_en || step;
`else
    assign w_fetch_go = 1'b1;
`endif

    branch_resolve u_branch_resolve (
        .i_op    (r_ir.op),
        .i_gt    (r_flags[2]),
        .i_lt    (r_flags[1]),
        .i_eq    (r_flags[0]),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_exb   <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
            r_exb   <= w_exb_next;
            r_flags <= w_flags_next;
        end
    end

    // r_exb carries b, then the resolved pointer, then the loaded word, so
    // ex_b and the effective address always come from one register.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_exb_next   = r_exb;
        w_flags_next = r_flags;
        w_reg_we     = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;

        case (r_state)
            FETCH: begin
                if (w_fetch_go) begin
                    w_ir_next    = instr_t'(bus.rom_data[DATA_WIDTH-1:0]);
                    w_exb_next   = bus.rom_data[WORD_WIDTH-1:0];
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                w_pc_next = r_pc + 1'b1;
                case (r_ir.op)
                    NOP:           w_state_next = FETCH;
                    MOV, ADD, CMP: w_state_next = EXEC;
                    LDR:           w_state_next = (r_ir.s == 2'b01) ? MEM_PTR : MEM_DATA;
                    STR:           w_state_next = MEM_DATA;
                    B, BGT, BLT, BEQ: w_state_next = BRANCH;
                    default:       w_state_next = TRAP;
                endcase
            end
            EXEC: begin
                if (r_ir.op == CMP) begin
                    w_flags_next = {bus.alu_gt, bus.alu_lt, bus.alu_eq};
                end else begin
                    w_reg_we = 1'b1;
                end
                w_state_next = FETCH;
            end
            MEM_PTR: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_exb;
                if (bus.mem_ack) begin
                    w_exb_next   = bus.mem_rdata;
                    w_state_next = MEM_DATA;
                end
            end
            MEM_DATA: begin
                w_mem_req  = 1'b1;
                w_mem_we   = (r_ir.op == STR);
                w_mem_addr = r_exb;
                if (bus.mem_ack) begin
                    if (r_ir.op == LDR) begin
                        w_exb_next   = bus.mem_rdata;
                        w_state_next = WB;
                    end else begin
                        w_state_next = FETCH;
                    end
                end
            end
            WB: begin
                w_reg_we     = 1'b1;
                w_state_next = FETCH;
            end
            BRANCH: begin
                if (w_taken) begin
                    w_pc_next = r_ir.b[ADDR_WIDTH-1:0];
                end
                w_state_next = FETCH;
            end
            TRAP: begin
                w_state_next = TRAP;
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    assign bus.rom_addr = r_pc;
    assign bus.ex_op    = r_ir.op;
    assign bus.ex_sel   = norm_sel(r_ir.s);
    assign bus.ex_a     = r_ir.a;
    assign bus.ex_b     = r_exb;
    assign bus.reg_we   = w_reg_we;
    assign bus.mem_req  = w_mem_req;
    assign bus.mem_we   = w_mem_we;
    assign bus.mem_addr = w_mem_addr;
    assign bus.trap     = (r_state == TRAP);

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the complex CPU.
- Owns the program counter, addresses the asynchronous instruction ROM, and latches the 38-bit word {opcode[3:0], s[1:0], a[15:0], b[15:0]}.
- Drives register-file/ALU strobes, runs the data-memory handshake for ldr/str, latches compare flags, and resolves b/bgt/blt/beq.

Parameters:
- DATA_WIDTH, 38, instruction word width.
- ADDR_WIDTH, 12, ROM address / PC width.
- WORD_WIDTH, 16, operand and data-memory word width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_WIDTH  instruction address (= pc).
- rom_data  in  DATA_WIDTH  instruction word, valid combinationally from rom_addr.
- ex_op  out  4  latched opcode to datapath.
- ex_sel  out  2  latched s field.
- ex_a  out  WORD_WIDTH  latched a field.
- ex_b  out  WORD_WIDTH  latched b field; replaced by the pointer value during indirect ldr.
- reg_we  out  1  one-cycle register-file write strobe.
- alu_gt, alu_lt, alu_eq  in  1 each  combinational compare results for the current ex_a/ex_b.
- mem_req  out  1  data-memory request, held until ack.
- mem_we  out  1  1 = write (str), 0 = read.
- mem_addr  out  WORD_WIDTH  data-memory address.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  WORD_WIDTH  read data.
- trap  out  1  sticky; set on an illegal opcode.

Behaviour:
- Reset values:
  - pc = 0, state = FETCH, IR = 0, flags gt/lt/eq = 0.
  - reg_we, mem_req, mem_we, trap = 0; mem_addr = 0.
  - ex_* = 0.
- FETCH: rom_addr = pc; IR <= rom_data at the clock edge; go to DECODE.
- DECODE: ex_* are driven from IR; pc <= pc+1, modulo 2^ADDR_WIDTH (4095 wraps to 0).
- DECODE dispatch by opcode:
  - 0000 nop -> FETCH.
  - 0001 mov, 1001 add -> EXEC.
  - 0100 cmp -> EXEC.
  - 0010 ldr -> MEM_PTR if s=01, else MEM_DATA.
  - 0011 str -> MEM_DATA.
  - 0101/0110/0111/1000 branch -> BRANCH.
  - any other opcode -> TRAP.
- EXEC:
  - mov/add: reg_we = 1 for exactly one cycle.
  - cmp: flags <= {alu_gt, alu_lt, alu_eq}, no reg_we.
  - Then FETCH.
- MEM_PTR:
  - mem_req = 1, mem_we = 0, mem_addr = b.
  - On mem_ack, latch mem_rdata as the effective address; go to MEM_DATA.
- MEM_DATA:
  - mem_req = 1; mem_addr = effective address (b for direct).
  - mem_we = 1 for str, else 0.
  - str write data is the register named by a[15:12] (s=00) or the immediate a (s=01); the datapath selects it via ex_sel.
  - On mem_ack:
    - ldr: reg_we = 1 the next cycle (WB state), ex_b = mem_rdata, then FETCH.
    - str: go to FETCH.
  - Without ack, stay in MEM_DATA; mem_req and mem_addr must remain stable.
- BRANCH:
  - Taken if b, or bgt with gt, or blt with lt, or beq with eq.
  - Taken: pc <= b[ADDR_WIDTH-1:0], overriding the DECODE increment.
  - Not taken: pc keeps the DECODE increment.
  - Then FETCH.
- Flags change only on cmp; branches and other instructions leave them untouched.
- TRAP: terminal. trap = 1, no strobes asserted, pc frozen; exit only by rst.
- rst asserted in any state, including mid-memory handshake: on the next edge all state is reset and mem_req drops.
- Cycle counts:
  - nop 2; mov/add/cmp/branch 3.
  - str 3 + wait cycles; direct ldr 4 + wait cycles; indirect ldr 5 + wait cycles.
  - Zero wait cycles means ack in the first request cycle.
- Illegal s values (e.g. ldr s=10) are treated as s=00.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds inputs step_en (1) and step (1).
  - While step_en = 1, FETCH waits until step = 1 before latching the instruction; one instruction completes per step pulse.
- Undefined: ports absent; the sequencer free-runs.

Decomposition:
- Shared package cpu_pkg:
  - opcode enum: NOP, MOV, LDR, STR, CMP, B, BGT, BLT, BEQ, ADD.
  - state enum: FETCH, DECODE, EXEC, MEM_PTR, MEM_DATA, WB, BRANCH, TRAP.
  - instr_t packed struct {op, s, a, b}; field-width constants.
- Optional sub-module branch_resolve: combinational, takes {op, gt, lt, eq}, outputs taken. All else stays in cpu_sequencer.

Test Plan:
- rst, then ROM: mov r0,#1 {0001,00,0000,0001}; nop
  -> reg_we pulses in cycle 3, ex_b = 0x0001; pc = 2 after 5 cycles.
- cmp r1,r0 with alu_gt = 1, then bgt 0x062
  -> pc = 0x062 after the branch.
- Same sequence with alu_gt = 0 -> pc = branch address + 1.
- Indirect ldr r3,[0x45C]: ack on the 2nd cycle of each request; first read returns 0x0460, second 0x0007
  -> mem_addr 0x45C then 0x460; reg_we once, with ex_b = 0x0007.
- str r5,0x451 with ack delayed 4 cycles
  -> mem_req/mem_we/mem_addr = 0x451 stable for 4 cycles; no reg_we.
- Opcode 1111 -> trap = 1 and pc frozen.
- rst asserted during a MEM_DATA wait -> mem_req = 0 and pc = 0 next cycle.
- pc at 0xFFF executing nop -> pc wraps to 0x000.
